// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: FSM state
//               encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states; the encoding is fixed so it can be probed externally.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SA_WIDTH_DEF = 8;

endpackage
`default_nettype wire

// File: rtl/serial_adder_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : half_adder / full_adder
// Description : Single-bit arithmetic cells used as the serial adder's
//               bit slice. full_adder is two half adders plus an OR gate.
//   half_adder ports : i_a, i_b -> o_s (sum), o_c (carry)
//   full_adder ports : A, B, CI -> S (sum), CO (carry out)
// Revision    : 1.0 - initial release
// ============================================================================
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder (
    input  logic A,
    input  logic B,
    input  logic CI,
    output logic S,
    output logic CO
);
    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_adder u_ha_ab (
        .i_a (A),
        .i_b (B),
        .o_s (w_s1),
        .o_c (w_c1)
    );

    half_adder u_ha_ci (
        .i_a (w_s1),
        .i_b (CI),
        .o_s (S),
        .o_c (w_c2)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign CO = w_c1 | w_c2;
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB first, one bit per clock, using a
//               single full_adder cell and a carry flip-flop. Sequenced by a
//               START / BUSY / DONE handshake with back-to-back support.
//   Optional    : define SERIAL_ADDER_SUB_EN to add the SUB input, which turns
//                 the operation into A - B - CIN (COUT=1 means no borrow).
//   Ports :
//     CLK   in   rising-edge clock
//     RST   in   synchronous active-high reset
//     START in   request, sampled in IDLE or DONE
//     A, B  in   WIDTH-bit operands, captured on accepted START
//     CIN   in   carry-in, captured on accepted START
//     SUB   in   (SERIAL_ADDER_SUB_EN only) subtract select
//     BUSY  out  high while bits are being computed
//     DONE  out  one-cycle result-valid pulse
//     S     out  WIDTH-bit sum, held until next operation runs
//     COUT  out  final carry-out
//     OVF   out  signed overflow
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             SUB,
`endif
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             OVF
);

    localparam int                 c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_q,     w_a_d;
    logic [WIDTH-1:0]   r_b_q,     w_b_d;
    logic [WIDTH-1:0]   r_sum_q,   w_sum_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_carry_q, w_carry_d;
    logic               r_cout_q,  w_cout_d;
    logic               r_ovf_q,   w_ovf_d;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic               w_fa_s;
    logic               w_fa_co;

    // Subtraction is A + ~B + ~CIN: inverting the borrow-in turns CIN=0
    // into the +1 of two's complement negation.
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load   = SUB ? ~B : B;
    assign w_cin_load = SUB ^ CIN;
`else
    assign w_b_load   = B;
    assign w_cin_load = CIN;
`endif

    full_adder u_cell (
        .A  (r_a_q[0]),
        .B  (r_b_q[0]),
        .CI (r_carry_q),
        .S  (w_fa_s),
        .CO (w_fa_co)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_sum_d   = r_sum_q;
        w_cnt_d   = r_cnt_q;
        w_carry_d = r_carry_q;
        w_cout_d  = r_cout_q;
        w_ovf_d   = r_ovf_q;

        unique case (r_state_q)
            ST_IDLE, ST_DONE: begin
                // Results stay untouched on accept; they only change once
                // the first RUN edge shifts a new bit in.
                if (START) begin
                    w_a_d     = A;
                    w_b_d     = w_b_load;
                    w_carry_d = w_cin_load;
                    w_cnt_d   = '0;
                    w_state_d = ST_RUN;
                end else begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                w_sum_d   = {w_fa_s, r_sum_q[WIDTH-1:1]};
                w_a_d     = {1'b0, r_a_q[WIDTH-1:1]};
                w_b_d     = {1'b0, r_b_q[WIDTH-1:1]};
                w_carry_d = w_fa_co;
                w_cnt_d   = r_cnt_q + c_CNT_ONE;
                if (r_cnt_q == c_CNT_LAST) begin
                    // On the MSB slice the carry FF holds the carry into
                    // the MSB, so overflow is that XOR the carry out.
                    w_cout_d  = w_fa_co;
                    w_ovf_d   = r_carry_q ^ w_fa_co;
                    w_state_d = ST_DONE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q <= ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_sum_q   <= '0;
            r_cnt_q   <= '0;
            r_carry_q <= 1'b0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_sum_q   <= w_sum_d;
            r_cnt_q   <= w_cnt_d;
            r_carry_q <= w_carry_d;
            r_cout_q  <= w_cout_d;
            r_ovf_q   <= w_ovf_d;
        end
    end

    assign BUSY = (r_state_q == ST_RUN);
    assign DONE = (r_state_q == ST_DONE);
    assign S    = r_sum_q;
    assign COUT = r_cout_q;
    assign OVF  = r_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder. A WIDTH=4 instance runs
//               a table of directed vectors plus handshake corner cases; a
//               WIDTH=8 instance runs a random sweep against an integer
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start4, cin4, sub4;
    logic [3:0] a4, b4;
    logic       busy4, done4, cout4, ovf4;
    logic [3:0] s4;

    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] s8;

    int tests = 0;
    int fails = 0;

    serial_adder #(.WIDTH(4)) u_dut4 (
        .CLK   (clk),
        .RST   (rst),
        .START (start4),
        .A     (a4),
        .B     (b4),
        .CIN   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB   (sub4),
`endif
        .BUSY  (busy4),
        .DONE  (done4),
        .S     (s4),
        .COUT  (cout4),
        .OVF   (ovf4)
    );

    serial_adder #(.WIDTH(8)) u_dut8 (
        .CLK   (clk),
        .RST   (rst),
        .START (start8),
        .A     (a8),
        .B     (b8),
        .CIN   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .SUB   (sub8),
`endif
        .BUSY  (busy8),
        .DONE  (done8),
        .S     (s8),
        .COUT  (cout8),
        .OVF   (ovf8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
        logic       ovf;
    } vec4_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: integer arithmetic, 8-bit. Returns {ovf, cout, s}.
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
        int ua, ub, sa, sb, ci, ru, rs;
        logic [7:0] s;
        logic co, ov;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); ci = cin;
        if (sub) begin
            ru = ua - ub - ci;
            rs = sa - sb - ci;
            co = (ru >= 0);
        end else begin
            ru = ua + ub + ci;
            rs = sa + sb + ci;
            co = (ru > 255);
        end
        s  = 8'(ru);
        ov = (rs > 127) || (rs < -128);
        return {ov, co, s};
    endfunction

    // One complete WIDTH=4 operation; waits (bounded) for DONE.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                       output int busy_n, output logic got_done);
        @(posedge clk); #1;
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        busy_n = 0; got_done = 1'b0;
        for (int n = 0; n < 20 && !got_done; n++) begin
            if (done4) got_done = 1'b1;
            else begin
                if (busy4) busy_n++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, output logic got_done);
        @(posedge clk); #1;
        a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        got_done = 1'b0;
        for (int n = 0; n < 30 && !got_done; n++) begin
            if (done8) got_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec4_t vecs[6];
        int    busy_n;
        logic  got;
        int    t1, t2, nd;
        logic [5:0] r1, r2;
        logic  bubble_ok;
        logic  saw_done;
        logic  sub;
        logic [7:0] ra, rb;
        logic  rc;
        logic [9:0] exp8;

        vecs[0] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0};
        vecs[2] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
        vecs[3] = '{4'h7, 4'h0, 1'b1, 4'h8, 1'b0, 1'b1};
        vecs[4] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1};
        vecs[5] = '{4'hA, 4'h5, 1'b1, 4'h0, 1'b1, 1'b0};

        rst = 1'b1;
        start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
        start8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_w4", {busy4, done4, cout4, ovf4, s4}, 32'h0);
        check("reset_w8", {busy8, done8, cout8, ovf8, s8}, 32'h0);
        rst = 1'b0;

        // Directed table on the 4-bit instance
        for (int i = 0; i < 6; i++) begin
            op4(vecs[i].a, vecs[i].b, vecs[i].cin, busy_n, got);
            check("w4_done_seen", {31'd0, got}, 32'd1);
            check("w4_busy_cycles", busy_n, 32'd4);
            check("w4_result", {cout4, ovf4, s4}, {vecs[i].cout, vecs[i].ovf, vecs[i].s});
            if (i == 0) begin
                @(posedge clk); #1;
                check("w4_done_one_cycle", {busy4, done4}, 32'd0);
                check("w4_result_held", {cout4, ovf4, s4}, {vecs[i].cout, vecs[i].ovf, vecs[i].s});
            end
        end

        // Back-to-back: START held through DONE, operands changed after accept
        @(posedge clk); #1;
        a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        a4 = 4'h9; b4 = 4'h6; cin4 = 1'b1;
        nd = 0; t1 = 0; t2 = 0; r1 = '0; r2 = '0; bubble_ok = 1'b0;
        for (int c = 0; c < 30 && nd < 2; c++) begin
            if (done4) begin
                if (nd == 0) begin t1 = c; r1 = {cout4, ovf4, s4}; end
                else begin t2 = c; r2 = {cout4, ovf4, s4}; end
                nd++;
            end
            @(posedge clk); #1;
            if (nd == 1 && start4) begin
                bubble_ok = busy4;
                start4 = 1'b0;
            end
        end
        check("b2b_two_dones", nd, 32'd2);
        check("b2b_no_bubble", {31'd0, bubble_ok}, 32'd1);
        check("b2b_spacing", t2 - t1, 32'd5);
        check("b2b_first", {26'd0, r1}, {26'd0, 1'b0, 1'b1, 4'h8});
        check("b2b_second", {26'd0, r2}, {26'd0, 1'b1, 1'b0, 4'h0});

        // START re-pulsed and operands changed mid-RUN must be ignored
        @(posedge clk); #1;
        a4 = 4'h2; b4 = 4'h4; cin4 = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        saw_done = 1'b0;
        for (int n = 0; n < 20 && !saw_done; n++) begin
            if (done4) saw_done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("midrun_done_seen", {31'd0, saw_done}, 32'd1);
        check("midrun_result", {cout4, ovf4, s4}, {1'b0, 1'b0, 4'h7});
        @(posedge clk); #1;
        check("midrun_back_to_idle", {busy4, done4}, 32'd0);

        // Reset on the second RUN cycle aborts with cleared outputs
        @(posedge clk); #1;
        a4 = 4'h3; b4 = 4'h5; cin4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", {busy4, done4, cout4, ovf4, s4}, 32'h0);
        saw_done = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (done4 || busy4) saw_done = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);

        // Random sweep on the 8-bit instance
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            op8(ra, rb, rc, sub, got);
            exp8 = ref8(ra, rb, rc, sub);
            tests++;
            if (!got || {ovf8, cout8, s8} !== exp8) begin
                fails++;
                $display("FAIL rand8 a=%0h b=%0h cin=%0b sub=%0b: got done=%0b {ovf,cout,s}=%0h expected %0h",
                         ra, rb, rc, sub, got, {ovf8, cout8, s8}, exp8);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder. It adds two WIDTH-bit operands LSB-first, one bit per clock.
- Datapath is a single full-adder cell plus a carry flip-flop. The full adder is built from two half adders.
- Sequenced by a start/busy/done handshake.
- Successor to the combinational half-adder lab block. It adds width generalisation, carry-in/out, signed overflow and multi-cycle sequencing.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- START  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  operand A; captured on accepted START
- B  input  WIDTH  operand B; captured on accepted START
- CIN  input  1  carry-in; captured on accepted START
- BUSY  output  1  high while bits are being computed
- DONE  output  1  one-cycle pulse; result valid
- S  output  WIDTH  sum register; held until next accepted START
- COUT  output  1  final carry-out
- OVF  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- One clock domain, CLK. RST is synchronous and active-high; all state updates on the rising edge of CLK.
- Reset: state=IDLE; BUSY=0, DONE=0, S=0, COUT=0, OVF=0; internal shift registers, carry FF and bit counter cleared.
- States are IDLE, RUN and DONE.
- IDLE:
  - START=1 -> capture A, B into shift registers and CIN into the carry FF; counter=0; go to RUN.
  - START=0 -> stay in IDLE.
- RUN, per cycle (BUSY=1):
  - sum bit = a0 ^ b0 ^ c, taken through the full_adder cell.
  - The sum bit shifts into the MSB of S; the A and B shift registers shift right by one.
  - The carry FF is updated with the cell carry.
  - The counter increments.
  - When counter reaches WIDTH-1, also do the following, then go to DONE:
    - COUT = cell carry.
    - OVF = carry_in_to_bit(WIDTH-1) ^ cell carry.
- DONE: DONE=1 for exactly one cycle, BUSY=0.
  - START=1 -> accepted exactly as in IDLE (back-to-back operation, no bubble); go to RUN.
  - START=0 -> go to IDLE.
- Latency: START accepted at edge k; BUSY=1 for cycles k+1..k+WIDTH; DONE=1 in cycle k+WIDTH+1.
  - Throughput: one result per WIDTH+1 cycles.
- S, COUT and OVF change only during RUN.
  - They are stable from DONE until the first RUN edge of the next operation.
  - During RUN, S holds partial shifted data and is not valid.
- START while in RUN is ignored. Operand changes during RUN have no effect.
- RST asserted mid-RUN aborts the operation: next cycle is IDLE with all outputs 0, and no DONE pulse is issued.
- Arithmetic is modulo 2^WIDTH. {COUT,S} = A + B + CIN exactly.
- Counter width is $clog2(WIDTH).

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port SUB (1 bit), captured on accepted START.
  - SUB=1 -> B is captured as ~B and the carry FF loads ~CIN, so the result is A - B - CIN (borrow-in).
  - COUT=1 means no borrow. OVF is signed subtraction overflow.
- Undefined: port SUB absent; add-only behaviour as above.

Decomposition:
- Package serial_adder_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - default width constant SA_WIDTH_DEF=8.
- One sub-module, full_adder (A, B, CI -> S, CO), built from two half_adder instances and an OR gate.
  - It is instantiated once as the serial bit cell.

Test Plan:
- WIDTH=4, A=4'h3, B=4'h5, CIN=0, START pulse -> BUSY high for 4 cycles; DONE pulse in cycle 5; S=4'h8, COUT=0, OVF=1.
- WIDTH=4, A=4'hF, B=4'h1, CIN=0 -> S=4'h0, COUT=1, OVF=0; then A=4'hF, B=4'hF, CIN=1 -> S=4'hF, COUT=1, OVF=0.
- Back-to-back: START held high through DONE -> second operation enters RUN with no idle cycle. Two DONE pulses are exactly WIDTH+1 cycles apart, each result correct.
- START re-pulsed and A/B changed mid-RUN -> ignored; result matches the originally captured operands.
- RST asserted on the 2nd RUN cycle -> next cycle BUSY=0, DONE=0, S=0, COUT=0; no DONE pulse follows.
- WIDTH=8 random sweep (1000 ops, SUB_EN both ways) against a reference model {COUT,S}=A+B+CIN (or A-B-CIN) -> zero mismatches.
